// File: rtl/coeff_frame_loader.sv
// coeff_frame_loader: receives a framed 5x5 FIR kernel over a byte stream,
// verifies its XOR checksum, buffers it, then replays it as addr/data pairs.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   rx_data/rx_valid/rx_ready  incoming byte stream (valid/ready)
//   filter_addr[_valid/_ready] coefficient index channel (zero-extended)
//   filter_data[_valid/_ready] coefficient value channel (sign-extended)
//   busy                       high in any state other than IDLE
//   load_done                  one-cycle pulse after the last pair
//   frame_err                  one-cycle pulse on checksum mismatch
module coeff_frame_loader #(
    parameter int         NUM_COEFF = 25,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] filter_addr,
    output logic        filter_addr_valid,
    input  logic        filter_addr_ready,
    output logic [31:0] filter_data,
    output logic        filter_data_valid,
    input  logic        filter_data_ready,
    output logic        busy,
    output logic        load_done,
    output logic        frame_err
);

    localparam int KW = $clog2(NUM_COEFF);
    localparam int CW = KW + 1;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        SEND,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    csum;
    logic [KW-1:0] idx;
    logic [KW-1:0] nidx;
    logic [15:0]   shadow [NUM_COEFF];
    logic          a_fin;
    logic          d_fin;

    function automatic logic [31:0] sext(input logic [15:0] c);
        return {{16{c[15]}}, c};
    endfunction

    assign rx_ready = (state == IDLE) || (state == RECV) || (state == CHECK);
    assign busy     = (state != IDLE);
    assign nidx     = idx + KW'(1);

    // A channel counts as finished for the current pair if it already
    // handshook earlier (valid dropped) or is handshaking this cycle.
    assign a_fin = !filter_addr_valid || filter_addr_ready;
    assign d_fin = !filter_data_valid || filter_data_ready;

    // Shadow buffer: plain storage, contents irrelevant after reset.
    always_ff @(posedge clk) begin
        if (state == RECV && rx_valid) begin
            if (cnt[0])
                shadow[cnt[CW-1:1]][7:0] <= rx_data;
            else
                shadow[cnt[CW-1:1]][15:8] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            csum              <= '0;
            idx               <= '0;
            filter_addr       <= '0;
            filter_addr_valid <= 1'b0;
            filter_data       <= '0;
            filter_data_valid <= 1'b0;
            load_done         <= 1'b0;
            frame_err         <= 1'b0;
        end else begin
            load_done <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= RECV;
                        cnt   <= '0;
                        csum  <= '0;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        csum <= csum ^ rx_data;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(2 * NUM_COEFF - 1))
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state             <= SEND;
                            idx               <= '0;
                            filter_addr       <= '0;
                            filter_data       <= sext(shadow[0]);
                            filter_addr_valid <= 1'b1;
                            filter_data_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                SEND: begin
                    if (a_fin && d_fin) begin
                        if (idx == KW'(NUM_COEFF - 1)) begin
                            filter_addr_valid <= 1'b0;
                            filter_data_valid <= 1'b0;
                            load_done         <= 1'b1;
                            state             <= DONE;
                        end else begin
                            idx               <= nidx;
                            filter_addr       <= {{(32 - KW){1'b0}}, nidx};
                            filter_data       <= sext(shadow[nidx]);
                            filter_addr_valid <= 1'b1;
                            filter_data_valid <= 1'b1;
                        end
                    end else begin
                        if (filter_addr_valid && filter_addr_ready)
                            filter_addr_valid <= 1'b0;
                        if (filter_data_valid && filter_data_ready)
                            filter_data_valid <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_frame_loader.sv
// tb_coeff_frame_loader: directed bench for coeff_frame_loader.
// Sends framed kernels and checks the replayed addr/data pairs.
module tb_coeff_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] filter_addr;
    logic        filter_addr_valid;
    logic        filter_addr_ready = 1'b1;
    logic [31:0] filter_data;
    logic        filter_data_valid;
    logic        filter_data_ready = 1'b1;
    logic        busy;
    logic        load_done;
    logic        frame_err;

    coeff_frame_loader dut (
        .clk               (clk),
        .rst               (rst),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .filter_addr       (filter_addr),
        .filter_addr_valid (filter_addr_valid),
        .filter_addr_ready (filter_addr_ready),
        .filter_data       (filter_data),
        .filter_data_valid (filter_data_valid),
        .filter_data_ready (filter_data_ready),
        .busy              (busy),
        .load_done         (load_done),
        .frame_err         (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int mode = 0;
    int dwait = 0;
    logic [15:0] co [25];

    int cyc = 0;
    logic [31:0] aq [$];
    logic [31:0] dq [$];
    int t_first = 0;
    int t_last = 0;
    int t_ld = 0;
    int ld_cnt = 0;
    int fe_cnt = 0;
    int v_cnt = 0;
    int stab_err = 0;
    logic pa_v = 1'b0;
    logic pa_hs = 1'b0;
    logic pd_v = 1'b0;
    logic pd_hs = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;

    // Edge monitor: records handshakes, pulses and payload stability.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pa_v = 1'b0;
            pd_v = 1'b0;
        end else begin
            if (filter_addr_valid || filter_data_valid) v_cnt++;
            if (pa_v && !pa_hs && (!filter_addr_valid || filter_addr !== pa))
                stab_err++;
            if (pd_v && !pd_hs && (!filter_data_valid || filter_data !== pd))
                stab_err++;
            if (filter_addr_valid && filter_addr_ready) begin
                if (aq.size() == 0) t_first = cyc;
                aq.push_back(filter_addr);
            end
            if (filter_data_valid && filter_data_ready) begin
                dq.push_back(filter_data);
                t_last = cyc;
            end
            if (load_done) begin
                ld_cnt++;
                t_ld = cyc;
            end
            if (frame_err) fe_cnt++;
            pa_v  = filter_addr_valid;
            pa_hs = filter_addr_valid && filter_addr_ready;
            pa    = filter_addr;
            pd_v  = filter_data_valid;
            pd_hs = filter_data_valid && filter_data_ready;
            pd    = filter_data;
        end
    end

    // Ready driver: tied high (mode 0) or backpressure (mode 1).
    initial begin
        forever begin
            @(posedge clk);
            if (filter_data_valid && filter_data_ready) dwait = 0;
            #1;
            if (mode == 0) begin
                filter_addr_ready = 1'b1;
                filter_data_ready = 1'b1;
            end else begin
                filter_addr_ready = 1'($urandom_range(0, 1));
                if (!filter_data_valid) begin
                    filter_data_ready = 1'b0;
                end else if (dwait < 3) begin
                    filter_data_ready = 1'b0;
                    dwait++;
                end else begin
                    filter_data_ready = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        aq.delete();
        dq.delete();
        t_first = 0;
        t_last = 0;
        t_ld = 0;
        ld_cnt = 0;
        fe_cnt = 0;
        v_cnt = 0;
        stab_err = 0;
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'h00;
        put(8'hA5);
        for (int k = 0; k < 25; k++) begin
            put(co[k][15:8]);
            put(co[k][7:0]);
            x = x ^ co[k][15:8] ^ co[k][7:0];
        end
        put(x ^ flip);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!load_done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {31'b0, load_done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic int bad_pairs();
        int b;
        b = 0;
        if (aq.size() != 25 || dq.size() != 25) return 1000;
        for (int i = 0; i < 25; i++) begin
            if (aq[i] !== 32'(i)) b++;
            if (dq[i] !== {{16{co[i][15]}}, co[i]}) b++;
        end
        return b;
    endfunction

    initial begin
        int n;
        for (int k = 0; k < 25; k++) co[k] = 16'h0100 + 16'(k);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        chk("rst_avalid", {31'b0, filter_addr_valid}, 32'd0);
        chk("rst_dvalid", {31'b0, filter_data_valid}, 32'd0);
        chk("rst_addr", filter_addr, 32'd0);
        chk("rst_data", filter_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame, readies tied high
        clear_mon();
        send_frame(8'h00);
        chk("t1_avalid0", {31'b0, filter_addr_valid}, 32'd1);
        chk("t1_dvalid0", {31'b0, filter_data_valid}, 32'd1);
        chk("t1_addr0", filter_addr, 32'd0);
        chk("t1_data0", filter_data, 32'h00000100);
        chk("t1_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        wait_done("t1_done");
        chk("t1_pairs", 32'(bad_pairs()), 32'd0);
        chk("t1_rate", 32'(t_last - t_first), 32'd24);
        chk("t1_done_lat", 32'(t_ld - t_first), 32'd25);
        chk("t1_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("t1_rx_ready_after", {31'b0, rx_ready}, 32'd1);
        chk("t1_busy_after", {31'b0, busy}, 32'd0);

        // Negative coefficient sign extension
        co[12] = 16'hFFF6;
        clear_mon();
        send_frame(8'h00);
        wait_done("t2_done");
        chk("t2_pairs", 32'(bad_pairs()), 32'd0);
        chk("t2_neg", dq.size() > 12 ? dq[12] : 32'hDEADBEEF, 32'hFFFFFFF6);

        // Corrupted checksum
        clear_mon();
        send_frame(8'h01);
        chk("t3_err_pulse", {31'b0, frame_err}, 32'd1);
        chk("t3_rx_ready", {31'b0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t3_err_clear", {31'b0, frame_err}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_valid", 32'(v_cnt), 32'd0);
        chk("t3_err_cnt", 32'(fe_cnt), 32'd1);
        clear_mon();
        send_frame(8'h00);
        wait_done("t3_reload_done");
        chk("t3_reload_pairs", 32'(bad_pairs()), 32'd0);

        // Backpressure on both channels
        mode = 1;
        clear_mon();
        send_frame(8'h00);
        wait_done("t4_done");
        chk("t4_pairs", 32'(bad_pairs()), 32'd0);
        chk("t4_stable", 32'(stab_err), 32'd0);
        chk("t4_ld_cnt", 32'(ld_cnt), 32'd1);
        mode = 0;
        @(posedge clk);
        #1;

        // Garbage before sync, sync value inside payload
        co[3] = 16'hA5A5;
        co[7] = 16'h00A5;
        clear_mon();
        put(8'h00);
        put(8'h55);
        send_frame(8'h00);
        wait_done("t5_done");
        chk("t5_pairs", 32'(bad_pairs()), 32'd0);

        // Reset mid-SEND at pair 10
        clear_mon();
        send_frame(8'h00);
        n = 0;
        while (!(filter_addr_valid && filter_addr == 32'd10) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_reach10", {31'b0, filter_addr_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_avalid_rst", {31'b0, filter_addr_valid}, 32'd0);
        chk("t6_dvalid_rst", {31'b0, filter_data_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rx_ready", {31'b0, rx_ready}, 32'd1);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        clear_mon();
        send_frame(8'h00);
        wait_done("t6_done");
        chk("t6_pairs", 32'(bad_pairs()), 32'd0);
        chk("t6_addr0", aq.size() > 0 ? aq[0] : 32'hDEADBEEF, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
